// File: rtl/nibble_pack_pkg.sv
// Shared constants and the {valid, word} record carried down the nibble-pack pipeline.
package nibble_pack_pkg;

  localparam int NIB_W   = 4;
  localparam int NIBBLES = 4;
  localparam int WORD_W  = NIB_W * NIBBLES;
  localparam int CNT_W   = $clog2(NIBBLES);

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] word;
  } packed_word_t;

endpackage

// File: rtl/nibble_pipe_stage.sv
// One delay stage of the word pipeline; idle stages carry all-zero data.
module nibble_pipe_stage
  import nibble_pack_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  packed_word_t i_d,
  output packed_word_t o_q
);

  packed_word_t r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      r_q.valid <= i_d.valid;
      r_q.word  <= i_d.valid ? i_d.word : '0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/e_nibble_pack_3.sv
// Packs an MSB-first serial nibble stream into 16-bit words and delivers each
// completed word LATENCY edges after its final nibble is sampled.
module e_nibble_pack_3
  import nibble_pack_pkg::*;
#(
  parameter int LATENCY = 3
)
(
  input  logic              _i_clk,
  input  logic              _i_rst_n,
  input  logic [NIB_W-1:0]  _i_nibble,
  input  logic              _i_nibble_valid,
  input  logic              _i_flush,
  output logic [WORD_W:0]   __output
);

  logic [CNT_W-1:0]        r_count;
  // Only the low three nibbles are ever read back; the oldest one leaves the word on completion.
  logic [WORD_W-NIB_W-1:0] r_shift;
  logic                    w_accept;
  logic                    w_last;
  packed_word_t            w_stage [0:LATENCY];

  assign w_accept = _i_nibble_valid && !_i_flush;
  assign w_last   = w_accept && (r_count == CNT_W'(NIBBLES - 1));

  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) begin
      r_count <= '0;
      r_shift <= '0;
    end else if (_i_flush) begin
      r_count <= '0;
      r_shift <= '0;
    end else if (_i_nibble_valid) begin
      r_shift <= {r_shift[WORD_W-2*NIB_W-1:0], _i_nibble};
      r_count <= w_last ? '0 : r_count + CNT_W'(1);
    end
  end

  assign w_stage[0] = {w_last, r_shift, _i_nibble};

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      nibble_pipe_stage u_stage (
        .i_clk   (_i_clk),
        .i_rst_n (_i_rst_n),
        .i_d     (w_stage[gi]),
        .o_q     (w_stage[gi+1])
      );
    end
  endgenerate

  assign __output = w_stage[LATENCY];

endmodule

// File: tb/tb_e_nibble_pack_3.sv
// Directed bench for e_nibble_pack_3: reset, assembly, back-to-back, gaps, flush, async reset.
module tb_e_nibble_pack_3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  nibble;
  logic        nib_valid;
  logic        flush;
  logic [16:0] dut_out;

  int checks;
  int failures;

  e_nibble_pack_3 #(.LATENCY(3)) dut (
    ._i_clk          (clk),
    ._i_rst_n        (rst_n),
    ._i_nibble       (nibble),
    ._i_nibble_valid (nib_valid),
    ._i_flush        (flush),
    .__output        (dut_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs for one cycle, then land 1 time unit past the sampling edge.
  task automatic cyc(input logic v, input logic [3:0] n, input logic f);
    nib_valid = v;
    nibble    = n;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [16:0] exp);
    checks++;
    assert (dut_out === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, dut_out, exp);
      end
    $display("check %-12s observed=%h expected=%h", tag, dut_out, exp);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    nib_valid = 1'b0;
    nibble    = 4'h0;
    flush     = 1'b0;

    // T1: nibbles driven while in reset produce nothing
    cyc(1, 4'h5, 0); chk("t1_rst0", 17'h0);
    cyc(1, 4'h6, 0); chk("t1_rst1", 17'h0);
    cyc(1, 4'h7, 0); cyc(1, 4'h8, 0); chk("t1_rst2", 17'h0);
    rst_n = 1'b1;
    cyc(0, 4'h0, 0); chk("t1_idle0", 17'h0);
    cyc(0, 4'h0, 0); chk("t1_idle1", 17'h0);

    // T2: 1,0,0,0 -> 16'h1000 exactly three edges after the final nibble
    cyc(1, 4'h1, 0); chk("t2_n0", 17'h0);
    cyc(1, 4'h0, 0);
    cyc(1, 4'h0, 0);
    cyc(1, 4'h0, 0); chk("t2_lat1", 17'h0);
    cyc(0, 4'h0, 0); chk("t2_lat2", 17'h0);
    cyc(0, 4'h0, 0); chk("t2_word", 17'h1_1000);
    cyc(0, 4'h0, 0); chk("t2_after", 17'h0);

    // T3: back-to-back words ABCD then 1234
    cyc(1, 4'hA, 0); cyc(1, 4'hB, 0); cyc(1, 4'hC, 0);
    cyc(1, 4'hD, 0); chk("t3_l1", 17'h0);
    cyc(1, 4'h1, 0); chk("t3_l2", 17'h0);
    cyc(1, 4'h2, 0); chk("t3_abcd", 17'h1_ABCD);
    cyc(1, 4'h3, 0); chk("t3_gap", 17'h0);
    cyc(1, 4'h4, 0); chk("t3_m1", 17'h0);
    cyc(0, 4'h0, 0); chk("t3_m2", 17'h0);
    cyc(0, 4'h0, 0); chk("t3_1234", 17'h1_1234);
    cyc(0, 4'h0, 0); chk("t3_after", 17'h0);

    // T4: gaps hold the partial word
    cyc(1, 4'h9, 0); cyc(0, 4'h3, 0); chk("t4_gap0", 17'h0);
    cyc(1, 4'h8, 0); cyc(0, 4'h3, 0); cyc(0, 4'h3, 0); chk("t4_gap1", 17'h0);
    cyc(1, 4'h7, 0);
    cyc(1, 4'h6, 0); chk("t4_l1", 17'h0);
    cyc(0, 4'h0, 0); chk("t4_l2", 17'h0);
    cyc(0, 4'h0, 0); chk("t4_9876", 17'h1_9876);
    cyc(0, 4'h0, 0); chk("t4_after", 17'h0);

    // T5: flush with a valid nibble drops it and the partial word
    cyc(1, 4'h5, 0); cyc(1, 4'h5, 0);
    cyc(1, 4'hF, 1);
    cyc(1, 4'h1, 0); chk("t5_a", 17'h0);
    cyc(1, 4'h2, 0); chk("t5_b", 17'h0);
    cyc(1, 4'h3, 0); chk("t5_c", 17'h0);
    cyc(1, 4'h4, 0); chk("t5_d", 17'h0);
    cyc(0, 4'h0, 0); chk("t5_e", 17'h0);
    cyc(0, 4'h0, 0); chk("t5_1234", 17'h1_1234);
    cyc(0, 4'h0, 0); chk("t5_after", 17'h0);

    // Flush coinciding with the final nibble drops the whole word
    cyc(1, 4'h7, 0); cyc(1, 4'h7, 0); cyc(1, 4'h7, 0);
    cyc(1, 4'h7, 1); chk("t5f_0", 17'h0);
    cyc(0, 4'h0, 0); chk("t5f_1", 17'h0);
    cyc(0, 4'h0, 0); chk("t5f_2", 17'h0);
    cyc(0, 4'h0, 0); chk("t5f_3", 17'h0);

    // T6: async reset one cycle after BEEF completes
    cyc(1, 4'hB, 0); cyc(1, 4'hE, 0); cyc(1, 4'hE, 0);
    cyc(1, 4'hF, 0);
    cyc(0, 4'h0, 0); chk("t6_pre", 17'h0);
    #2 rst_n = 1'b0;
    #1 chk("t6_async", 17'h0);
    #1 rst_n = 1'b1;
    cyc(0, 4'h0, 0); chk("t6_post0", 17'h0);
    cyc(0, 4'h0, 0); chk("t6_post1", 17'h0);
    cyc(0, 4'h0, 0); chk("t6_post2", 17'h0);

    // Reset mid-word: the next nibble starts a fresh word
    cyc(1, 4'hC, 0); cyc(1, 4'hD, 0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cyc(1, 4'hA, 0); cyc(1, 4'h5, 0); cyc(1, 4'h5, 0);
    cyc(1, 4'hA, 0); chk("t6m_l1", 17'h0);
    cyc(0, 4'h0, 0); chk("t6m_l2", 17'h0);
    cyc(0, 4'h0, 0); chk("t6m_a55a", 17'h1_A55A);
    cyc(0, 4'h0, 0); chk("t6m_after", 17'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
